// File: rtl/vga_frame_monitor.sv
// VGA stream monitor: checks line/frame timing and signs each frame with a CRC-16 over active pixels.
// Latency: frame_done/frame_crc/frame_cnt/v_err register 1 cycle after the vs assert-edge sample.
// Backpressure: none; passive tap, one pixel per clock, never stalls. Optional watchdog: VGA_MON_TIMEOUT_EN.
module vga_frame_monitor #(
    parameter int COLOR_W  = 4,
    parameter int H_TOTAL  = 1344,
    parameter int V_TOTAL  = 806,
    parameter int H_ACTIVE = 1024,
    parameter int V_ACTIVE = 768,
    parameter bit SYNC_POL = 1'b1,
    parameter int FRAMES   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               hs,
    input  logic               vs,
    input  logic               hblnk,
    input  logic               vblnk,
    input  logic [COLOR_W-1:0] r,
    input  logic [COLOR_W-1:0] g,
    input  logic [COLOR_W-1:0] b,
    output logic               frame_done,
    output logic [15:0]        frame_crc,
    output logic [7:0]         frame_cnt,
    output logic               h_err,
    output logic               v_err,
    output logic               capture_done,
    output logic               timeout
);

    localparam int          PIX_W   = 3 * COLOR_W;
    localparam logic [11:0] H_EXP   = 12'(H_TOTAL);
    localparam logic [11:0] V_EXP   = 12'(V_TOTAL);
    localparam logic [21:0] PIX_EXP = 22'(H_ACTIVE * V_ACTIVE);
    localparam logic [7:0]  FR_EXP  = 8'(FRAMES);

    typedef enum logic [1:0] {IDLE, WAIT_SYNC, MEASURE, DONE} state_t;

    state_t      state;
    logic        hs_q;
    logic        vs_q;
    logic        first_line;
    logic [11:0] h_cnt;
    logic [11:0] line_cnt;
    logic [21:0] pix_cnt;
    logic [15:0] crc;

    // CRC-16-CCITT, MSB first, whole pixel word folded in one clock
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [PIX_W-1:0] d);
        logic [15:0] x;
        x = c;
        for (int i = PIX_W - 1; i >= 0; i--)
            x = {x[14:0], 1'b0} ^ ((x[15] ^ d[i]) ? 16'h1021 : 16'h0000);
        return x;
    endfunction

    logic        hs_edge;
    logic        vs_edge;
    logic        pix_act;
    logic [15:0] crc_next;
    logic [11:0] h_cnt_inc;
    logic [11:0] line_cnt_hs;
    logic [21:0] pix_cnt_nx;
    logic        h_bad;
    logic        v_bad;

    assign hs_edge     = (hs_q != SYNC_POL) && (hs == SYNC_POL);
    assign vs_edge     = (vs_q != SYNC_POL) && (vs == SYNC_POL);
    assign pix_act     = !hblnk && !vblnk;
    assign crc_next    = pix_act ? crc_step(crc, {r, g, b}) : crc;
    assign h_cnt_inc   = (h_cnt == 12'hFFF) ? h_cnt : h_cnt + 12'd1;
    assign line_cnt_hs = (hs_edge && line_cnt != 12'hFFF) ? line_cnt + 12'd1 : line_cnt;
    assign pix_cnt_nx  = (pix_act && pix_cnt != 22'h3FFFFF) ? pix_cnt + 22'd1 : pix_cnt;

    // Saturated counters can never be trusted to compare correctly, so they force an error.
    assign h_bad = (h_cnt == 12'hFFF) || (h_cnt + 12'd1 != H_EXP);
    assign v_bad = (line_cnt_hs == 12'hFFF) || (line_cnt_hs != V_EXP)
                || (pix_cnt_nx == 22'h3FFFFF) || (pix_cnt_nx != PIX_EXP);

`ifdef VGA_MON_TIMEOUT_EN
    localparam logic [31:0] WD_LIMIT = 32'(2 * H_TOTAL * V_TOTAL);
    logic [31:0] wd_cnt;
    logic        wd_hit;
    assign wd_hit = !vs_edge && (wd_cnt + 32'd1 >= WD_LIMIT);
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            hs_q         <= ~SYNC_POL;
            vs_q         <= ~SYNC_POL;
            first_line   <= 1'b0;
            h_cnt        <= '0;
            line_cnt     <= '0;
            pix_cnt      <= '0;
            crc          <= 16'hFFFF;
            frame_done   <= 1'b0;
            frame_crc    <= '0;
            frame_cnt    <= '0;
            h_err        <= 1'b0;
            v_err        <= 1'b0;
            capture_done <= 1'b0;
`ifdef VGA_MON_TIMEOUT_EN
            wd_cnt       <= '0;
            timeout      <= 1'b0;
`endif
        end else begin
            hs_q       <= hs;
            vs_q       <= vs;
            frame_done <= 1'b0;
            if (!en && state != IDLE) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (en) begin
                            state        <= WAIT_SYNC;
                            frame_cnt    <= '0;
                            h_err        <= 1'b0;
                            v_err        <= 1'b0;
                            capture_done <= 1'b0;
`ifdef VGA_MON_TIMEOUT_EN
                            wd_cnt       <= '0;
                            timeout      <= 1'b0;
`endif
                        end
                    end
                    WAIT_SYNC: begin
                        if (vs_edge) begin
                            state      <= MEASURE;
                            h_cnt      <= '0;
                            line_cnt   <= '0;
                            pix_cnt    <= '0;
                            crc        <= 16'hFFFF;
                            first_line <= 1'b1;
                        end
`ifdef VGA_MON_TIMEOUT_EN
                        wd_cnt <= vs_edge ? 32'd0 : wd_cnt + 32'd1;
                        if (wd_hit) begin
                            timeout      <= 1'b1;
                            capture_done <= 1'b1;
                            state        <= DONE;
                        end
`endif
                    end
                    MEASURE: begin
                        h_cnt   <= h_cnt_inc;
                        pix_cnt <= pix_cnt_nx;
                        crc     <= crc_next;
                        // The line that ends on this hs edge is closed before any frame close below.
                        if (hs_edge) begin
                            if (!first_line && h_bad)
                                h_err <= 1'b1;
                            first_line <= 1'b0;
                            h_cnt      <= '0;
                            line_cnt   <= line_cnt_hs;
                        end
                        if (vs_edge) begin
                            if (v_bad)
                                v_err <= 1'b1;
                            frame_crc  <= crc_next;
                            frame_done <= 1'b1;
                            frame_cnt  <= frame_cnt + 8'd1;
                            h_cnt      <= '0;
                            line_cnt   <= '0;
                            pix_cnt    <= '0;
                            crc        <= 16'hFFFF;
                            if (frame_cnt + 8'd1 == FR_EXP) begin
                                state        <= DONE;
                                capture_done <= 1'b1;
                            end
                        end
`ifdef VGA_MON_TIMEOUT_EN
                        wd_cnt <= vs_edge ? 32'd0 : wd_cnt + 32'd1;
                        if (wd_hit) begin
                            timeout      <= 1'b1;
                            capture_done <= 1'b1;
                            state        <= DONE;
                        end
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Bench for vga_frame_monitor: table of frame scenarios plus en-drop, async-reset and watchdog sequences.
// Expected frame signatures are queued as frames are driven and popped on each frame_done.
module tb_vga_frame_monitor;

    localparam int HT = 16;
    localparam int VT = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       hs = 1'b0;
    logic       vs = 1'b0;
    logic       hblnk = 1'b1;
    logic       vblnk = 1'b1;
    logic [3:0] r = '0;
    logic [3:0] g = '0;
    logic [3:0] b = '0;
    logic       frame_done;
    logic [15:0] frame_crc;
    logic [7:0] frame_cnt;
    logic       h_err;
    logic       v_err;
    logic       capture_done;
    logic       timeout;

    vga_frame_monitor #(
        .COLOR_W(4), .H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(10), .V_ACTIVE(6),
        .SYNC_POL(1'b1), .FRAMES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .hs(hs), .vs(vs), .hblnk(hblnk), .vblnk(vblnk),
        .r(r), .g(g), .b(b), .frame_done(frame_done), .frame_crc(frame_crc),
        .frame_cnt(frame_cnt), .h_err(h_err), .v_err(v_err),
        .capture_done(capture_done), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;
    int done_pulses = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    typedef struct {
        logic [15:0] crc;
        logic [7:0]  cnt;
        logic        h;
        logic        v;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    always @(negedge clk) begin
        if (frame_done === 1'b1) begin
            done_pulses++;
            if (sb.size() == 0) begin
                check("spurious_frame_done", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("frame_crc", frame_crc, mon_e.crc);
                check("frame_cnt_at_done", frame_cnt, mon_e.cnt);
                check("h_err_at_done", h_err, mon_e.h);
                check("v_err_at_done", v_err, mon_e.v);
            end
        end
    end

    function automatic logic [15:0] ref_crc(input logic [15:0] c, input logic [11:0] w);
        logic [15:0] x;
        x = c;
        for (int i = 11; i >= 0; i--)
            x = (x << 1) ^ ({16{x[15] ^ w[i]}} & 16'h1021);
        return x;
    endfunction

    task automatic tick(input logic h, input logic v, input logic hb, input logic vb,
                        input logic [3:0] rr, input logic [3:0] gg, input logic [3:0] bb);
        hs = h; vs = v; hblnk = hb; vblnk = vb; r = rr; g = gg; b = bb;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0);
    endtask

    // Lines 0-1 carry vs and are blank; active area is lines 2..7, columns 4..13; hs on columns 0-1.
    task automatic drive_frame(input int hline, input int hdelta, input bit pat,
                               input int first, input int last, output logic [15:0] crc);
        logic [15:0] c;
        logic [31:0] x;
        logic [31:0] y;
        logic [3:0]  rr, gg, bb;
        logic        act;
        int          len;
        c = 16'hFFFF;
        for (int line = first; line <= last; line++) begin
            len = (line == hline) ? HT + hdelta : HT;
            for (int col = 0; col < len; col++) begin
                act = (line >= 2) && (line < VT) && (col >= 4) && (col < 14);
                x = 32'(col - 4);
                y = 32'(line - 2);
                if (act) begin
                    rr = pat ? x[3:0] : 4'h0;
                    gg = pat ? y[3:0] : 4'h0;
                    bb = pat ? 4'hA : 4'h0;
                    c = ref_crc(c, {rr, gg, bb});
                end else begin
                    rr = 4'hF; gg = 4'h5; bb = 4'h3;
                end
                tick(col < 2, line < 2, !((col >= 4) && (col < 14)),
                     !((line >= 2) && (line < VT)), rr, gg, bb);
            end
        end
        crc = c;
    endtask

    typedef struct {
        string name;
        int    hline;
        int    hdelta;
        int    extra;
        bit    pat;
        logic  exp_h;
        logic  exp_v;
    } vec_t;
    vec_t vecs[6];

    task automatic do_reset();
        rst_n = 1'b0;
        en = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
    endtask

    initial begin
        logic [15:0] crc0, crc1, dummy;
        int n;

        vecs[0] = '{"nominal",     -1,  0, 0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{"short_line",   3, -1, 0, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{"long_line",    5,  1, 0, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{"extra_line",  -1,  0, 1, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{"pattern",     -1,  0, 0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{"short_extra",  4, -1, 1, 1'b1, 1'b1, 1'b1};

        rst_n = 1'b0;
        idle(2);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_frame_crc", frame_crc, 16'h0);
        check("rst_frame_cnt", frame_cnt, 8'h0);
        check("rst_h_err", h_err, 1'b0);
        check("rst_v_err", v_err, 1'b0);
        check("rst_capture_done", capture_done, 1'b0);
        check("rst_timeout", timeout, 1'b0);

        foreach (vecs[k]) begin
            do_reset();
            done_pulses = 0;
            en = 1'b1;
            idle(4);
            drive_frame(vecs[k].hline, vecs[k].hdelta, vecs[k].pat, 0, VT - 1 + vecs[k].extra, crc0);
            sb.push_back('{crc0, 8'd1, vecs[k].exp_h, vecs[k].exp_v});
            drive_frame(-1, 0, vecs[k].pat, 0, VT - 1, crc1);
            sb.push_back('{crc1, 8'd2, vecs[k].exp_h, vecs[k].exp_v});
            drive_frame(-1, 0, 1'b0, 0, VT - 1, dummy);
            drive_frame(-1, 0, 1'b1, 0, VT - 1, dummy);
            drive_frame(-1, 0, 1'b0, 0, 0, dummy);
            idle(2);
            if (vecs[k].pat) check({vecs[k].name, "_crc_repeat"}, crc1, crc0);
            check({vecs[k].name, "_pulses"}, done_pulses, 2);
            check({vecs[k].name, "_sb_empty"}, sb.size(), 0);
            check({vecs[k].name, "_frame_cnt"}, frame_cnt, 8'd2);
            check({vecs[k].name, "_capture_done"}, capture_done, 1'b1);
            check({vecs[k].name, "_h_err"}, h_err, vecs[k].exp_h);
            check({vecs[k].name, "_v_err"}, v_err, vecs[k].exp_v);
            check({vecs[k].name, "_timeout"}, timeout, 1'b0);
            check({vecs[k].name, "_crc_held"}, frame_crc, crc1);
        end

        // en dropped mid-frame, then reasserted
        do_reset();
        done_pulses = 0;
        en = 1'b1;
        idle(4);
        drive_frame(-1, 0, 1'b1, 0, VT - 1, crc0);
        sb.push_back('{crc0, 8'd1, 1'b0, 1'b0});
        drive_frame(-1, 0, 1'b1, 0, 3, dummy);
        en = 1'b0;
        drive_frame(-1, 0, 1'b1, 4, VT - 1, dummy);
        drive_frame(-1, 0, 1'b1, 0, VT - 1, dummy);
        check("endrop_pulses", done_pulses, 1);
        check("endrop_cnt_held", frame_cnt, 8'd1);
        check("endrop_crc_held", frame_crc, crc0);
        check("endrop_capture_done", capture_done, 1'b0);
        en = 1'b1;
        idle(3);
        check("restart_cnt_clear", frame_cnt, 8'd0);
        drive_frame(-1, 0, 1'b0, 0, VT - 1, crc0);
        sb.push_back('{crc0, 8'd1, 1'b0, 1'b0});
        drive_frame(-1, 0, 1'b1, 0, VT - 1, crc1);
        sb.push_back('{crc1, 8'd2, 1'b0, 1'b0});
        drive_frame(-1, 0, 1'b0, 0, 0, dummy);
        idle(2);
        check("restart_pulses", done_pulses, 3);
        check("restart_sb_empty", sb.size(), 0);
        check("restart_frame_cnt", frame_cnt, 8'd2);
        check("restart_capture_done", capture_done, 1'b1);

        // asynchronous reset in the middle of a measured frame
        do_reset();
        en = 1'b1;
        idle(4);
        drive_frame(3, -1, 1'b1, 0, VT - 1, crc0);
        sb.push_back('{crc0, 8'd1, 1'b1, 1'b0});
        drive_frame(-1, 0, 1'b1, 0, 4, dummy);
        check("pre_arst_h_err", h_err, 1'b1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_frame_done", frame_done, 1'b0);
        check("arst_frame_crc", frame_crc, 16'h0);
        check("arst_frame_cnt", frame_cnt, 8'h0);
        check("arst_h_err", h_err, 1'b0);
        check("arst_v_err", v_err, 1'b0);
        check("arst_capture_done", capture_done, 1'b0);
        check("arst_timeout", timeout, 1'b0);
        en = 1'b0;
        @(posedge clk);
        #1;
        idle(1);
        rst_n = 1'b1;
        idle(1);

`ifdef VGA_MON_TIMEOUT_EN
        en = 1'b1;
        n = 0;
        while (timeout !== 1'b1 && n < 400) begin
            idle(1);
            n++;
        end
        check("timeout_cycles", n, 257);
        check("timeout_flag", timeout, 1'b1);
        check("timeout_capture_done", capture_done, 1'b1);
        en = 1'b0;
        idle(1);
`else
        n = 0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_frame_monitor.md
Name: vga_frame_monitor

Overview:
Synthesizable, parametrised VGA stream monitor for capture and self-check in simulation and on FPGA.
- Taps the same hs/vs/blank/RGB bus that the top-level bench feeds to the image writer.
- Measures line and frame timing against parameters and flags mismatches.
- Computes a CRC-16 over the active RGB pixels of each frame.
- Stops after a parametrised number of frames, so benches and hardware can compare a frame signature instead of a TIFF image.

Parameters:
COLOR_W, 4, bits per colour channel
H_TOTAL, 1344, expected pixel clocks per line
V_TOTAL, 806, expected lines per frame
H_ACTIVE, 1024, expected active pixels per line
V_ACTIVE, 768, expected active lines per frame
SYNC_POL, 1, level of asserted hs/vs (1 = active-high)
FRAMES, 2, number of frames to measure before stopping (1..255)

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
en  in  1  start/keep monitoring; low returns the block to IDLE
hs  in  1  horizontal sync
vs  in  1  vertical sync
hblnk  in  1  horizontal blank (1 = blanked)
vblnk  in  1  vertical blank (1 = blanked)
r, g, b  in  COLOR_W each  pixel colour
frame_done  out  1  one-cycle pulse at the end of each measured frame
frame_crc  out  16  CRC of the last completed frame
frame_cnt  out  8  number of completed frames
h_err  out  1  sticky: a line length differed from H_TOTAL
v_err  out  1  sticky: a frame's line count differed from V_TOTAL, or its active pixel count differed from H_ACTIVE*V_ACTIVE
capture_done  out  1  high once FRAMES frames have been measured
timeout  out  1  sticky watchdog flag (only with the optional feature; tied 0 otherwise)

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0; state IDLE; counters 0; CRC register 0xFFFF; previous hs/vs registers at the deasserted level (!SYNC_POL).
- Edge detect: an assert edge is the previous sample deasserted and the current sample equal to SYNC_POL; hs/vs are registered every cycle in every state.
- States:
  - IDLE: if en=1, go to WAIT_SYNC; clear frame_cnt, h_err, v_err, capture_done, timeout.
  - WAIT_SYNC: on the first vs assert edge, go to MEASURE; zero the h/line/pixel counters; CRC = 0xFFFF.
  - MEASURE:
    - h_cnt increments every cycle.
    - On an hs assert edge: if h_cnt+1 != H_TOTAL, set h_err; h_cnt = 0; line_cnt++. The first hs edge after entering MEASURE is not length-checked.
    - Active pixel (hblnk=0 and vblnk=0): pix_cnt++; CRC updated.
    - On a vs assert edge: check line_cnt against V_TOTAL and pix_cnt against H_ACTIVE*V_ACTIVE, set v_err on either mismatch; frame_crc = CRC including any pixel in that same cycle; pulse frame_done the next cycle; frame_cnt++; restart counters and CRC.
    - If frame_cnt reaches FRAMES: go to DONE, capture_done=1.
  - DONE: hold all outputs.
- en low in any non-IDLE state: IDLE on the next clock. frame_crc and frame_cnt are held; no frame_done pulse.
- CRC:
  - CRC-16-CCITT, poly 0x1021, init 0xFFFF, no reflection, no final XOR.
  - Each active pixel feeds the word {r,g,b}, 3*COLOR_W bits, MSB first.
  - Fully unrolled: one pixel per clock, no stall.
- Counters:
  - h_cnt and line_cnt are 12 bits; pix_cnt is 22 bits.
  - All saturate at their maximum; no wrap.
  - A saturated count forces the corresponding error at the next check.
- Simultaneous hs and vs assert edges: the hs line is processed first (counted and checked), then the frame close.
- frame_done latency: 1 cycle after the vs assert-edge sample.

Optional Feature:
VGA_MON_TIMEOUT_EN:
- Defined: a 32-bit watchdog runs in WAIT_SYNC and MEASURE and clears on every vs assert edge. If it reaches 2*H_TOTAL*V_TOTAL, timeout is set (sticky) and the state goes to DONE with capture_done=1.
- Undefined: no watchdog; timeout is tied 0.

Test Plan:
- Bench parameters for all tests: H_TOTAL=16, V_TOTAL=8, H_ACTIVE=10, V_ACTIVE=6, FRAMES=2.
- Nominal: correct timing, all active pixels RGB=0 -> frame_done pulses twice; frame_cnt=2; capture_done=1; h_err=v_err=0; frame_crc equals the bench reference CRC of 60 zero words (12-bit).
- Short line: one line of 15 clocks in frame 1 -> h_err=1 from that hs edge onward; v_err=0; frame_crc unaffected if active pixels are unchanged.
- Extra line: V_TOTAL+1 = 9 lines in frame 1 -> v_err=1 at frame 1 end; frame_cnt still increments.
- Pattern: active pixel = {r=x[3:0], g=y[3:0], b=0xA} -> frame_crc matches the reference model; an identical second frame gives an identical CRC.
- en dropped mid-frame, then reasserted -> IDLE the next cycle with no frame_done; on restart, counts begin at the next vs edge and frame_cnt clears to 0.
- Async reset mid-MEASURE -> all outputs 0 immediately, without a clock edge. With VGA_MON_TIMEOUT_EN and vs held low, timeout=1 after 256 cycles.
